// File: rtl/solve_ctrl_pkg.sv
// Shared types and constants for the grid-solver start/done controller.
package solve_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OK      = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input status_t s);
    case (s)
      ST_OK:      return SEG_S;
      ST_FAIL:    return SEG_F;
      ST_TIMEOUT: return SEG_T;
      default:    return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/solve_ctrl_key_conditioner.sv
// Key input conditioning: 2-flop synchronizer, counter debounce, rising-edge press pulse.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      // Toggle only after DEBOUNCE_CYCLES consecutive disagreeing samples
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/solve_ctrl.sv
// Start/done handshake initiator for the grid solver.
// Optional status display encoder enabled by SOLVE_CTRL_SEG_EN.
module solve_ctrl
  import solve_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32,
  parameter int TIMEOUT_CYCLES  = 2**24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_req,
  output logic             grid_reset,
  output logic             grid_start,
  input  logic             done_success,
  input  logic             done_failure,
  output logic             busy,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycles,
  output logic [6:0]       status_seg
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_n;
  status_t          status_q, status_n;
  logic [CNT_W-1:0] cycles_n;
  logic             grid_reset_n, grid_start_n, busy_n;
  logic             key_level, key_press, go;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
    .clock (clock),
    .reset (reset),
    .raw   (start_req),
    .level (key_level),
    .press (key_press)
  );

  assign go = key_press & key_level;

  always_comb begin
    state_n      = state;
    status_n     = status_q;
    cycles_n     = cycles;
    grid_reset_n = 1'b0;
    grid_start_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_n      = CLEAR;
          status_n     = ST_IDLE;
          cycles_n     = '0;
          grid_reset_n = 1'b1;
        end
      end
      CLEAR: begin
        state_n      = START;
        grid_start_n = 1'b1;
      end
      START: state_n = RUN;
      RUN: begin
        // Priority: success, then failure, then timeout
        if (done_success) begin
          state_n  = DONE;
          status_n = ST_OK;
        end else if (done_failure) begin
          state_n  = DONE;
          status_n = ST_FAIL;
        end else begin
          cycles_n = cycles + CNT_W'(1);
          if (cycles_n == TIMEOUT) begin
            state_n      = DONE;
            status_n     = ST_TIMEOUT;
            grid_reset_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == CLEAR) || (state_n == START) || (state_n == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      status_q   <= ST_IDLE;
      cycles     <= '0;
      grid_reset <= 1'b1;
      grid_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      status_q   <= status_n;
      cycles     <= cycles_n;
      grid_reset <= grid_reset_n;
      grid_start <= grid_start_n;
      busy       <= busy_n;
    end
  end

  assign status = status_q;

`ifdef SOLVE_CTRL_SEG_EN
  logic [6:0] seg_q;

  always_ff @(posedge clock) begin
    if (reset) seg_q <= SEG_DASH;
    else       seg_q <= seg_encode(status_n);
  end

  assign status_seg = seg_q;
`else
  assign status_seg = SEG_BLANK;
`endif

endmodule

// File: tb/tb_solve_ctrl.sv
// Self-checking bench for solve_ctrl: directed handshake steps plus randomized runs vs an outcome model.
module tb_solve_ctrl;

  localparam int DB = 4;
  localparam int TO = 100;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_req = 1'b0;
  logic          done_success = 1'b0;
  logic          done_failure = 1'b0;
  logic          grid_reset, grid_start, busy;
  logic [1:0]    status;
  logic [CW-1:0] cycles;
  logic [6:0]    status_seg;

  int npass = 0;
  int ntot  = 0;
  int gs_cnt = 0;
  int gr_cnt = 0;

  solve_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_req    (start_req),
    .grid_reset   (grid_reset),
    .grid_start   (grid_start),
    .done_success (done_success),
    .done_failure (done_failure),
    .busy         (busy),
    .status       (status),
    .cycles       (cycles),
    .status_seg   (status_seg)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle
  always @(negedge clock) begin
    if (grid_start) gs_cnt++;
    if (grid_reset) gr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int seg_of(input int st);
`ifdef SOLVE_CTRL_SEG_EN
    case (st)
      1:       return 7'b0010010;
      2:       return 7'b0001110;
      3:       return 7'b0000111;
      default: return 7'b0111111;
    endcase
`else
    return 7'b1111111;
`endif
  endfunction

  // Outcome of a run whose done flags appear d cycles into RUN
  function automatic int model_status(input int d, input bit s, input bit f);
    if (d < TO && (s || f)) return s ? 1 : 2;
    return 3;
  endfunction

  function automatic int model_cycles(input int d, input bit s, input bit f);
    if (d < TO && (s || f)) return d;
    return TO;
  endfunction

  // Press the key and follow CLEAR/START; returns at the first RUN cycle
  task automatic start_run(input bit keep, input bit noise);
    int gs0;
    bit found;
    gs0 = gs_cnt;
    found = 1'b0;
    start_req = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc(1);
      found = grid_reset;
    end
    chk("press_to_clear", found, 1);
    chk("clear_busy", busy, 1);
    chk("clear_no_start", grid_start, 0);
    chk("clear_status", status, 0);
    chk("clear_cycles", cycles, 0);
    done_success = noise;
    done_failure = noise;
    cyc(1);
    chk("start_pulse", grid_start, 1);
    chk("start_no_reset", grid_reset, 0);
    chk("start_busy", busy, 1);
    cyc(1);
    done_success = 1'b0;
    done_failure = 1'b0;
    if (!keep) start_req = 1'b0;
    chk("run_no_start", grid_start, 0);
    chk("run_busy", busy, 1);
    chk("run_status", status, 0);
    chk("run_cycles0", cycles, 0);
    chk("one_start_pulse", gs_cnt - gs0, 1);
  endtask

  initial begin
    int gs0, gr0, d, es, ec;
    bit s, f, mid;

    // Reset state
    cyc(3);
    chk("rst_grid_reset", grid_reset, 1);
    chk("rst_grid_start", grid_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_status", status, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_seg", status_seg, seg_of(0));
    reset = 1'b0;
    cyc(1);
    chk("idle_grid_reset", grid_reset, 0);

    // Bouncing key never debounces
    gs0 = gs_cnt; gr0 = gr_cnt;
    for (int i = 0; i < 20; i++) begin
      start_req = ~start_req;
      cyc(2);
    end
    start_req = 1'b0;
    cyc(8);
    chk("bounce_no_start", gs_cnt - gs0, 0);
    chk("bounce_no_reset", gr_cnt - gr0, 0);
    chk("bounce_busy", busy, 0);

    // Long hold gives a single press; finish with failure
    gs0 = gs_cnt;
    start_run(1'b1, 1'b0);
    cyc(11);
    start_req = 1'b0;
    cyc(15);
    chk("hold_one_press", gs_cnt - gs0, 1);
    chk("hold_cycles", cycles, 26);
    done_failure = 1'b1;
    cyc(1);
    chk("fail_status", status, 2);
    chk("fail_cycles", cycles, 26);
    chk("fail_busy", busy, 0);
    chk("fail_seg", status_seg, seg_of(2));
    cyc(3);
    chk("fail_hold_status", status, 2);
    done_failure = 1'b0;

    // Success 37 cycles into RUN
    start_run(1'b0, 1'b0);
    cyc(37);
    chk("s37_pre_cycles", cycles, 37);
    done_success = 1'b1;
    cyc(1);
    done_success = 1'b0;
    chk("s37_status", status, 1);
    chk("s37_cycles", cycles, 37);
    chk("s37_busy", busy, 0);
    chk("s37_seg", status_seg, seg_of(1));

    // Simultaneous success and failure
    start_run(1'b0, 1'b0);
    cyc(12);
    done_success = 1'b1;
    done_failure = 1'b1;
    cyc(1);
    done_success = 1'b0;
    done_failure = 1'b0;
    chk("both_status", status, 1);
    chk("both_cycles", cycles, 12);

    // Timeout with an ignored mid-run press and done noise in CLEAR/START
    start_run(1'b0, 1'b1);
    gs0 = gs_cnt; gr0 = gr_cnt;
    cyc(10);
    start_req = 1'b1;
    cyc(20);
    start_req = 1'b0;
    cyc(69);
    chk("to_pre_cycles", cycles, 99);
    chk("to_pre_busy", busy, 1);
    chk("to_pre_status", status, 0);
    cyc(1);
    chk("to_status", status, 3);
    chk("to_cycles", cycles, TO);
    chk("to_grid_reset", grid_reset, 1);
    chk("to_busy", busy, 0);
    chk("to_seg", status_seg, seg_of(3));
    cyc(1);
    chk("to_reset_drop", grid_reset, 0);
    done_success = 1'b1;
    cyc(3);
    done_success = 1'b0;
    chk("to_done_ignored", status, 3);
    chk("to_cycles_hold", cycles, TO);
    chk("to_one_reset", gr_cnt - gr0, 1);
    chk("to_press_ignored", gs_cnt - gs0, 0);

    // Randomized runs against the outcome model
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 120);
      s = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      mid = (d > 45) && ($urandom_range(0, 1) == 1);
      start_run(1'b0, 1'($urandom_range(0, 1)));
      gs0 = gs_cnt; gr0 = gr_cnt;
      for (int k = 0; k <= TO + 1; k++) begin
        if (k == d) begin
          done_success = s;
          done_failure = f;
        end
        if (mid && k == 5) start_req = 1'b1;
        if (mid && k == 25) start_req = 1'b0;
        cyc(1);
      end
      done_success = 1'b0;
      done_failure = 1'b0;
      es = model_status(d, s, f);
      ec = model_cycles(d, s, f);
      chk("rnd_status", status, es);
      chk("rnd_cycles", cycles, ec);
      chk("rnd_busy", busy, 0);
      chk("rnd_seg", status_seg, seg_of(es));
      chk("rnd_reset_pulses", gr_cnt - gr0, (es == 3) ? 1 : 0);
      chk("rnd_no_restart", gs_cnt - gs0, 0);
    end

    // Reset in the middle of a run
    start_run(1'b0, 1'b0);
    cyc(10);
    chk("mid_cycles", cycles, 10);
    reset = 1'b1;
    cyc(1);
    chk("mrst_grid_reset", grid_reset, 1);
    chk("mrst_grid_start", grid_start, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_status", status, 0);
    chk("mrst_cycles", cycles, 0);
    chk("mrst_seg", status_seg, seg_of(0));
    cyc(2);
    chk("mrst_hold_reset", grid_reset, 1);
    reset = 1'b0;
    gs0 = gs_cnt;
    cyc(5);
    chk("post_rst_idle_reset", grid_reset, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_start", gs_cnt - gs0, 0);
    start_run(1'b0, 1'b0);
    cyc(3);
    done_failure = 1'b1;
    cyc(1);
    done_failure = 1'b0;
    chk("post_rst_status", status, 2);
    chk("post_rst_cycles", cycles, 3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/solve_ctrl.md
Name: solve_ctrl

Overview:
- Initiator side of the grid solver's start/done handshake.
- Conditions the raw start request from the board key and sequences the grid through clear, start and run phases.
- Waits for done_success or done_failure, or for a timeout, while counting solve cycles, then latches the outcome for display.
- Sits between the board-level keys/HEX outputs and the grid instance in the top level.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized-input cycles required before the debounced level changes.
- CNT_W, 32: width of the solve-cycle counter.
- TIMEOUT_CYCLES, 2**24: number of RUN cycles without a done indication before the run is aborted; must be less than 2**CNT_W.

Ports:
- clock  in  1  single system clock; all state is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start_req  in  1  raw, asynchronous, active-high start request (inverted key).
- grid_reset  out  1  registered reset to the grid.
- grid_start  out  1  registered one-cycle start pulse to the grid.
- done_success  in  1  level from the grid: solved.
- done_failure  in  1  level from the grid: unsolvable.
- busy  out  1  high in CLEAR, START and RUN.
- status  out  2  latched result: 0 = idle/working, 1 = success, 2 = failure, 3 = timeout.
- cycles  out  CNT_W  RUN-cycle count of the current or most recent run.
- status_seg  out  7  active-low seven-segment code for status (see Optional Feature).

Behaviour:
- Reset values: state = IDLE, grid_reset = 1, grid_start = 0, busy = 0, status = 0, cycles = 0, status_seg = 7'b0111111. The synchronizer, debounce counter and debounced level are all cleared.
- Input conditioning:
  - start_req passes through a 2-flop synchronizer.
  - The debounced level toggles once the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing cycle clears the debounce counter.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - Falling edges produce nothing.
- State machine:
  - IDLE: grid_reset = 0. On press -> CLEAR.
  - CLEAR: exactly one cycle with grid_reset = 1; cycles cleared to 0; status cleared to 0 -> START.
  - START: exactly one cycle with grid_start = 1 -> RUN.
  - RUN:
    - Each cycle with no done: cycles increments.
    - On done_success -> DONE with status 1.
    - Otherwise, on done_failure -> DONE with status 2. Success wins if both are asserted in the same cycle.
    - Otherwise, when cycles reaches TIMEOUT_CYCLES -> DONE with status 3, and grid_reset is asserted for that one transition cycle.
    - A done arriving in the same cycle as timeout expiry wins over the timeout.
  - DONE: status and cycles hold. On press -> CLEAR (re-run).
- Latency: press pulse at cycle N. grid_reset = 1 at N+1, grid_start = 1 at N+2, busy = 1 from N+1. If done arrives at cycle M in RUN, status updates and busy falls at M+1.
- Presses during CLEAR, START or RUN are ignored; they are not queued.
- done_* levels in IDLE or DONE are ignored. done_* asserted during CLEAR or START is ignored, because the grid is still being reset or started.
- cycles never wraps, since timeout fires before 2**CNT_W.
- Reset asserted mid-run returns everything to the reset values on the next edge. grid_reset holds at 1 while reset is high.

Optional Feature:
- Macro: SOLVE_CTRL_SEG_EN.
- Defined: status_seg is registered, updated on the same edge as status.
  - '-' = 7'b0111111 for status 0
  - 'S' = 7'b0010010 for status 1
  - 'F' = 7'b0001110 for status 2
  - 't' = 7'b0000111 for status 3
- Undefined: status_seg is tied to 7'b1111111 (blank) and the encoder is not built. The port list is unchanged in both cases.

Decomposition:
- Package solve_ctrl_pkg holds:
  - state enum: IDLE, CLEAR, START, RUN, DONE
  - status enum: ST_IDLE = 2'd0, ST_OK = 2'd1, ST_FAIL = 2'd2, ST_TIMEOUT = 2'd3
  - seven-segment constants: SEG_DASH, SEG_S, SEG_F, SEG_T, SEG_BLANK
- One sub-module, key_conditioner (parameter DEBOUNCE_CYCLES; ports clock, reset, raw, level, press), containing the synchronizer, debounce and edge detection. It is reusable for the remaining keys.

Test Plan (DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 100, CNT_W = 8):
- Release reset, then hold start_req high for 20 cycles -> exactly one press pulse; then one cycle of grid_reset = 1, then one cycle of grid_start = 1, and busy = 1 from the grid_reset cycle.
- Toggle start_req every 2 cycles for 40 cycles -> no press pulse; state stays IDLE and grid_start is never 1.
- Start a run, then assert done_success 37 cycles into RUN -> next cycle status = 1, cycles = 37, busy = 0, status_seg = 7'b0010010 (with SOLVE_CTRL_SEG_EN).
- Start a run, then assert done_success and done_failure in the same cycle -> status = 1. Next press -> status returns to 0, cycles = 0 and a new grid_start pulse occurs.
- Start a run with no done -> after 100 RUN cycles status = 3, cycles = 100 and one grid_reset pulse. A second press during RUN in a separate run is ignored.
- Assert reset 10 cycles into RUN -> the next edge gives state IDLE, grid_reset = 1, cycles = 0, status = 0 and busy = 0.
